// File: rtl/mod_mul_il_stream_io_if.sv
// Stream and multiplier-side signals of the word-serial modular multiplier front-end.
// slave: the front-end's view. master: the upstream/multiplier environment's view.
interface mod_mul_il_stream_io_if #(
  parameter int unsigned NBITS = 4096,
  parameter int unsigned WBITS = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WBITS-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WBITS-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic [NBITS-1:0] mul_a;
  logic [NBITS-1:0] mul_b;
  logic [NBITS-1:0] mul_m;
  logic             mul_enable_p;
  logic [NBITS-1:0] mul_y;
  logic             mul_done_p;

  modport slave (
    input  in_valid, in_data, out_ready, mul_y, mul_done_p,
    output in_ready, out_valid, out_data, out_last, busy,
           mul_a, mul_b, mul_m, mul_enable_p
  );

  modport master (
    output in_valid, in_data, out_ready, mul_y, mul_done_p,
    input  in_ready, out_valid, out_data, out_last, busy,
           mul_a, mul_b, mul_m, mul_enable_p
  );
endinterface

// File: rtl/mod_mul_il_stream_io.sv
// Word-serial front-end: assembles m, a, b from a word stream, launches the
// interleaved modular multiplier, and streams the product back out LS word first.
module mod_mul_il_stream_io #(
  parameter int unsigned NBITS = 4096,
  parameter int unsigned WBITS = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  mod_mul_il_stream_io_if.slave io
);
  localparam int unsigned NWORDS = (NBITS + WBITS - 1) / WBITS;
  localparam int unsigned WCW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned OBW    = NWORDS * WBITS;

  typedef enum logic [2:0] {LOAD_M, LOAD_A, LOAD_B, START, WAIT, UNLOAD} state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [NBITS-1:0] m_q, m_d, a_q, a_d, b_q, b_d;
  logic [OBW-1:0]   obuf_q, obuf_d;

  logic             last_word;
  logic             loading;
  logic [NBITS-1:0] ins_word;
  logic [NBITS-1:0] ins_mask;

  assign last_word = (wcnt_q == WCW'(NWORDS - 1));
  assign loading   = (state_q == LOAD_M) || (state_q == LOAD_A) || (state_q == LOAD_B);

  // Word lane placed at wcnt*WBITS; anything shifted past NBITS falls off.
  assign ins_word = NBITS'(io.in_data) << (32'(wcnt_q) * WBITS);
  assign ins_mask = NBITS'({WBITS{1'b1}}) << (32'(wcnt_q) * WBITS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_M;
      wcnt_q  <= '0;
      m_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      obuf_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      m_q     <= m_d;
      a_q     <= a_d;
      b_q     <= b_d;
      obuf_q  <= obuf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    m_d     = m_q;
    a_d     = a_q;
    b_d     = b_q;
    obuf_d  = obuf_q;
    case (state_q)
      LOAD_M, LOAD_A, LOAD_B: begin
        if (io.in_valid) begin
          case (state_q)
            LOAD_M:  m_d = (m_q & ~ins_mask) | ins_word;
            LOAD_A:  a_d = (a_q & ~ins_mask) | ins_word;
            default: b_d = (b_q & ~ins_mask) | ins_word;
          endcase
          if (last_word) begin
            wcnt_d = '0;
            case (state_q)
              LOAD_M:  state_d = LOAD_A;
              LOAD_A:  state_d = LOAD_B;
              default: state_d = START;
            endcase
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (io.mul_done_p) begin
          obuf_d  = OBW'(io.mul_y);
          wcnt_d  = '0;
          state_d = UNLOAD;
        end
      end
      UNLOAD: begin
        if (io.out_ready) begin
          obuf_d = obuf_q >> WBITS;
          if (last_word) begin
            wcnt_d  = '0;
            state_d = LOAD_M;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = LOAD_M;
        wcnt_d  = '0;
      end
    endcase
  end

  // Outputs decode only registered state, never the live handshake inputs.
  assign io.in_ready     = loading;
  assign io.out_valid    = (state_q == UNLOAD);
  assign io.out_data     = obuf_q[WBITS-1:0];
  assign io.out_last     = (state_q == UNLOAD) && last_word;
  assign io.busy         = !((state_q == LOAD_M) && (wcnt_q == '0));
  assign io.mul_enable_p = (state_q == START);
  assign io.mul_a        = a_q;
  assign io.mul_b        = b_q;
  assign io.mul_m        = m_q;
endmodule

// File: tb/tb_mod_mul_il_stream_io.sv
// Directed bench for mod_mul_il_stream_io: a 64/32 instance and a 40/16 instance,
// with the bench standing in for the multiplier.
module tb_mod_mul_il_stream_io;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int en64 = 0, en40 = 0, hs64 = 0, hs40 = 0;

  mod_mul_il_stream_io_if #(.NBITS(64), .WBITS(32)) if64 ();
  mod_mul_il_stream_io_if #(.NBITS(40), .WBITS(16)) if40 ();

  mod_mul_il_stream_io #(.NBITS(64), .WBITS(32)) u64 (.clk(clk), .rst_n(rst_n), .io(if64));
  mod_mul_il_stream_io #(.NBITS(40), .WBITS(16)) u40 (.clk(clk), .rst_n(rst_n), .io(if40));

  always @(posedge clk) begin
    if (if64.mul_enable_p) en64 <= en64 + 1;
    if (if40.mul_enable_p) en40 <= en40 + 1;
    if (if64.out_valid && if64.out_ready) hs64 <= hs64 + 1;
    if (if40.out_valid && if40.out_ready) hs40 <= hs40 + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mm(input logic [63:0] a, input logic [63:0] b,
                                     input logic [63:0] m);
    logic [127:0] p;
    p = 128'(a) * 128'(b);
    if (m == 64'd0) return 64'd0;
    return 64'(p % 128'(m));
  endfunction

  task automatic put64(input logic [31:0] w, input int gap);
    repeat (gap) begin
      if64.in_valid = 1'b0;
      if64.in_data  = 32'hDEAD_BEEF;
      tick();
    end
    if64.in_valid = 1'b1;
    if64.in_data  = w;
    tick();
    if64.in_valid = 1'b0;
  endtask

  task automatic load64(input logic [63:0] m, input logic [63:0] a, input logic [63:0] b,
                        input bit gapped);
    logic [31:0] w [6];
    int gaps [6];
    gaps = '{0, 2, 1, 0, 3, 1};
    w[0] = m[31:0]; w[1] = m[63:32];
    w[2] = a[31:0]; w[3] = a[63:32];
    w[4] = b[31:0]; w[5] = b[63:32];
    for (int i = 0; i < 6; i++) put64(w[i], gapped ? gaps[i] : 0);
  endtask

  task automatic put40(input logic [15:0] w);
    if40.in_valid = 1'b1;
    if40.in_data  = w;
    tick();
    if40.in_valid = 1'b0;
  endtask

  task automatic load40(input logic [47:0] m, input logic [47:0] a, input logic [47:0] b);
    put40(m[15:0]); put40(m[31:16]); put40(m[47:32]);
    put40(a[15:0]); put40(a[31:16]); put40(a[47:32]);
    put40(b[15:0]); put40(b[31:16]); put40(b[47:32]);
  endtask

  task automatic mul64();
    if64.mul_y      = mm(if64.mul_a, if64.mul_b, if64.mul_m);
    if64.mul_done_p = 1'b1;
    tick();
    if64.mul_done_p = 1'b0;
  endtask

  task automatic mul40();
    if40.mul_y      = 40'(mm(64'(if40.mul_a), 64'(if40.mul_b), 64'(if40.mul_m)));
    if40.mul_done_p = 1'b1;
    tick();
    if40.mul_done_p = 1'b0;
  endtask

  task automatic chk_out64(input string tag, input logic [63:0] data, input logic last);
    chk({tag, "_valid"}, 64'(if64.out_valid), 64'd1);
    chk({tag, "_data"},  64'(if64.out_data),  data);
    chk({tag, "_last"},  64'(if64.out_last),  64'(last));
  endtask

  task automatic chk_out40(input string tag, input logic [63:0] data, input logic last);
    chk({tag, "_valid"}, 64'(if40.out_valid), 64'd1);
    chk({tag, "_data"},  64'(if40.out_data),  data);
    chk({tag, "_last"},  64'(if40.out_last),  64'(last));
  endtask

  initial begin
    int en_base;
    int hs_base;
    rst_n = 1'b0;
    if64.in_valid = 1'b0; if64.in_data = '0; if64.out_ready = 1'b0;
    if64.mul_y = '0; if64.mul_done_p = 1'b0;
    if40.in_valid = 1'b0; if40.in_data = '0; if40.out_ready = 1'b0;
    if40.mul_y = '0; if40.mul_done_p = 1'b0;
    tick();
    tick();

    // Reset values
    chk("rst_in_ready", 64'(if64.in_ready), 64'd1);
    chk("rst_out_valid", 64'(if64.out_valid), 64'd0);
    chk("rst_out_last", 64'(if64.out_last), 64'd0);
    chk("rst_out_data", 64'(if64.out_data), 64'd0);
    chk("rst_enable", 64'(if64.mul_enable_p), 64'd0);
    chk("rst_busy", 64'(if64.busy), 64'd0);
    chk("rst_mul_m", if64.mul_m, 64'd0);
    chk("rst40_in_ready", 64'(if40.in_ready), 64'd1);
    chk("rst40_busy", 64'(if40.busy), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic operation: 7*9 mod 13 = 11
    load64(64'd13, 64'd7, 64'd9, 1'b0);
    chk("t1_en_hi", 64'(if64.mul_enable_p), 64'd1);
    chk("t1_in_ready_start", 64'(if64.in_ready), 64'd0);
    chk("t1_mul_m", if64.mul_m, 64'd13);
    chk("t1_mul_a", if64.mul_a, 64'd7);
    chk("t1_mul_b", if64.mul_b, 64'd9);
    tick();
    chk("t1_en_lo", 64'(if64.mul_enable_p), 64'd0);
    chk("t1_en_cnt", 64'(en64), 64'd1);
    if64.in_valid = 1'b1;
    if64.in_data  = 32'hFFFF_FFFF;
    tick();
    tick();
    if64.in_valid = 1'b0;
    chk("t1_wait_a_held", if64.mul_a, 64'd7);
    chk("t1_wait_ov", 64'(if64.out_valid), 64'd0);
    chk("t1_wait_busy", 64'(if64.busy), 64'd1);
    mul64();
    chk_out64("t1_w0", 64'd11, 1'b0);
    if64.out_ready = 1'b1;
    tick();
    chk_out64("t1_w1", 64'd0, 1'b1);
    tick();
    if64.out_ready = 1'b0;
    chk("t1_end_ov", 64'(if64.out_valid), 64'd0);
    chk("t1_end_in_ready", 64'(if64.in_ready), 64'd1);
    chk("t1_end_busy", 64'(if64.busy), 64'd0);
    chk("t1_end_en_cnt", 64'(en64), 64'd1);

    // Output backpressure
    hs_base = hs64;
    load64(64'd13, 64'd7, 64'd9, 1'b0);
    tick();
    mul64();
    tick();
    chk_out64("t2_stall0", 64'd11, 1'b0);
    tick();
    chk_out64("t2_stall1", 64'd11, 1'b0);
    if64.out_ready = 1'b1;
    tick();
    chk_out64("t2_w1", 64'd0, 1'b1);
    if64.out_ready = 1'b0;
    tick();
    chk_out64("t2_stall2", 64'd0, 1'b1);
    if64.out_ready = 1'b1;
    tick();
    if64.out_ready = 1'b0;
    chk("t2_hs_cnt", 64'(hs64 - hs_base), 64'd2);
    chk("t2_busy", 64'(if64.busy), 64'd0);
    chk("t2_ov", 64'(if64.out_valid), 64'd0);

    // Input gaps
    en_base = en64;
    load64(64'd13, 64'd7, 64'd9, 1'b1);
    chk("t3_en_hi", 64'(if64.mul_enable_p), 64'd1);
    chk("t3_mul_m", if64.mul_m, 64'd13);
    chk("t3_mul_a", if64.mul_a, 64'd7);
    chk("t3_mul_b", if64.mul_b, 64'd9);
    tick();
    chk("t3_en_cnt", 64'(en64 - en_base), 64'd1);
    mul64();
    chk_out64("t3_w0", 64'd11, 1'b0);
    if64.out_ready = 1'b1;
    tick();
    chk_out64("t3_w1", 64'd0, 1'b1);
    tick();
    if64.out_ready = 1'b0;

    // Spurious done in LOAD_A and in UNLOAD
    put64(32'd13, 0);
    put64(32'd0, 0);
    put64(32'd7, 0);
    if64.mul_y      = 64'h1234;
    if64.mul_done_p = 1'b1;
    tick();
    if64.mul_done_p = 1'b0;
    chk("t4_la_in_ready", 64'(if64.in_ready), 64'd1);
    chk("t4_la_ov", 64'(if64.out_valid), 64'd0);
    chk("t4_la_out_data", 64'(if64.out_data), 64'd0);
    chk("t4_la_busy", 64'(if64.busy), 64'd1);
    put64(32'd0, 0);
    put64(32'd9, 0);
    put64(32'd0, 0);
    chk("t4_en_hi", 64'(if64.mul_enable_p), 64'd1);
    chk("t4_mul_a", if64.mul_a, 64'd7);
    tick();
    mul64();
    chk_out64("t4_w0", 64'd11, 1'b0);
    if64.mul_y      = 64'hFFFF_FFFF_FFFF_FFFF;
    if64.mul_done_p = 1'b1;
    tick();
    if64.mul_done_p = 1'b0;
    chk_out64("t4_w0_after_done", 64'd11, 1'b0);
    if64.out_ready = 1'b1;
    tick();
    chk_out64("t4_w1", 64'd0, 1'b1);
    tick();
    if64.out_ready = 1'b0;
    chk("t4_end_ov", 64'(if64.out_valid), 64'd0);

    // Reset mid-load, then a fresh operation: 2^33 mod (2^32+7) = 0xFFFFFFF9
    put64(32'hAAAA_0001, 0);
    put64(32'hBBBB_0002, 0);
    put64(32'hCCCC_0003, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_in_ready", 64'(if64.in_ready), 64'd1);
    chk("t5_rst_busy", 64'(if64.busy), 64'd0);
    chk("t5_rst_mul_m", if64.mul_m, 64'd0);
    chk("t5_rst_mul_a", if64.mul_a, 64'd0);
    chk("t5_rst_ov", 64'(if64.out_valid), 64'd0);
    chk("t5_rst_en", 64'(if64.mul_enable_p), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    load64(64'h1_0000_0007, 64'h1_0000_0000, 64'd2, 1'b0);
    chk("t5_mul_m", if64.mul_m, 64'h1_0000_0007);
    chk("t5_mul_a", if64.mul_a, 64'h1_0000_0000);
    chk("t5_mul_b", if64.mul_b, 64'd2);
    tick();
    mul64();
    chk_out64("t5_w0", 64'hFFFF_FFF9, 1'b0);
    if64.out_ready = 1'b1;
    tick();
    chk_out64("t5_w1", 64'd0, 1'b1);
    tick();
    if64.out_ready = 1'b0;

    // Non-multiple width: 40/16, top byte of each third input word is junk
    load40(48'hABFF_FFFF_FFFB, 48'hCD00_0000_0002, 48'hEF00_0000_0003);
    chk("t6_en_hi", 64'(if40.mul_enable_p), 64'd1);
    chk("t6_mul_m", 64'(if40.mul_m), 64'hFF_FFFF_FFFB);
    chk("t6_mul_a", 64'(if40.mul_a), 64'd2);
    chk("t6_mul_b", 64'(if40.mul_b), 64'd3);
    tick();
    chk("t6_en_cnt", 64'(en40), 64'd1);
    mul40();
    chk_out40("t6_w0", 64'd6, 1'b0);
    if40.out_ready = 1'b1;
    tick();
    chk_out40("t6_w1", 64'd0, 1'b0);
    tick();
    chk_out40("t6_w2", 64'd0, 1'b1);
    tick();
    if40.out_ready = 1'b0;
    chk("t6_end_ov", 64'(if40.out_valid), 64'd0);
    chk("t6_end_busy", 64'(if40.busy), 64'd0);
    chk("t6_hs_cnt", 64'(hs40), 64'd3);

    // Partial final output word is zero-extended
    load40(48'h00FF_FFFF_FFFB, 48'h0000_0000_0002, 48'h0000_0000_0003);
    tick();
    if40.mul_y      = 40'hAB_1234_5678;
    if40.mul_done_p = 1'b1;
    tick();
    if40.mul_done_p = 1'b0;
    chk_out40("t7_w0", 64'h5678, 1'b0);
    if40.out_ready = 1'b1;
    tick();
    chk_out40("t7_w1", 64'h1234, 1'b0);
    tick();
    chk_out40("t7_w2", 64'h00AB, 1'b1);
    tick();
    if40.out_ready = 1'b0;
    chk("t7_end_in_ready", 64'(if40.in_ready), 64'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
